// File: rtl/edulent_fetch_pkg.sv
// Shared constants for the instruction fetch block.
// FETCH_PREFETCH_EN selects a 2-entry prefetch buffer. When it is not
// defined, the block uses a single holding register.
package edulent_fetch_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int RESET_PC_DEF = 0;
  localparam int FETCH_DEPTH  = 2;

`ifdef FETCH_PREFETCH_EN
  localparam int FETCH_BUF_DEPTH = FETCH_DEPTH;
`else
  // Single holding register; only one read may be outstanding.
  localparam int FETCH_BUF_DEPTH = FETCH_DEPTH / 2;
`endif

  localparam logic [7:0] OP_CALL = 8'hC1;
  localparam logic [7:0] OP_RET  = 8'hB0;

  // True for opcodes that redirect the fetch stream through the call stack.
  function automatic logic is_call_ret(input logic [7:0] op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Byte + address FIFO that holds fetched opcodes. A flush empties it in one
// cycle. The storage contents are kept across a flush, and the empty flag
// hides them. Read-side outputs are taken directly from the head entry.
module fetch_fifo #(
  parameter int                DEPTH    = 2,
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0,
  parameter int                CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_push,
  input  logic [7:0]        i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [7:0]        o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][7:0]        data_q;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full  = (cnt_q == CNT_W'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_count = cnt_q;

  // A pop frees the slot that a simultaneous push into a full FIFO needs.
  // A flush discards both the push and the pop.
  assign do_pop  = i_pop & ~o_empty & ~i_flush;
  assign do_push = i_push & ~i_flush & (~o_full | do_pop);

  // Next-state logic for the pointers and the occupancy count
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer and count registers
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Entry storage. It is reset so that the head shows 00 at RST_ADDR.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= RST_ADDR;
      end
    end else if (do_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_ptr_q == PTR_W'(i)) begin
          data_q[i] <= i_data;
          addr_q[i] <= i_addr;
        end
      end
    end
  end

  // Head entry mux
  always_comb begin
    o_data = data_q[0];
    o_addr = addr_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_ptr_q == PTR_W'(i)) begin
        o_data = data_q[i];
        o_addr = addr_q[i];
      end
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: reads opcode bytes from a one-cycle-latency program
// memory and buffers them for the control unit.
// FETCH_PREFETCH_EN: when defined, uses a 2-entry prefetch buffer. When
// undefined, uses a single holding register with one read in flight at most.
// A redirect flushes the buffer and toggles an epoch bit. A read that is
// still in flight carries the old epoch, so its data is dropped on arrival.
module instr_fetch
  import edulent_fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic [7:0]        i_mem_data,
  output logic [7:0]        o_opcode,
  output logic              o_opcode_valid,
  output logic [ADDR_W-1:0] o_pc,
  input  logic              i_next_instr,
  input  logic              i_pc_load,
  input  logic [ADDR_W-1:0] i_pc_target
);

  localparam int             DEPTH   = FETCH_BUF_DEPTH;
  localparam int             CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_epoch_q, rd_epoch_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              live_rd, issue, pop;
  logic              buf_full, buf_empty;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    pending;

  // An in-flight read counts toward the buffer's capacity only when it
  // belongs to the current epoch. A stale read does not block the first
  // fetch at a new target.
  assign live_rd = rd_vld_q & (rd_epoch_q == epoch_q);
  assign pending = {1'b0, occ} + {{CNT_W{1'b0}}, live_rd};

  // The read strobe is gated by reset, so it stays low while i_rstn is low.
  // The first read goes out in the first cycle after reset release.
  assign issue = i_rstn & ~buf_full & (pending < DEPTH_C);

  // A redirect in the same cycle wins over the pop.
  assign pop = i_next_instr & ~buf_empty & ~i_pc_load;

  assign o_mem_addr     = pc_q;
  assign o_mem_rd       = issue;
  assign o_opcode_valid = ~buf_empty;

  // Next fetch PC, epoch and in-flight read tag
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    rd_vld_d   = issue;
    rd_epoch_d = epoch_q;
    rd_addr_d  = pc_q;
    if (issue) pc_d = pc_q + ADDR_W'(1);
    if (i_pc_load) begin
      pc_d    = i_pc_target;
      epoch_d = ~epoch_q;
    end
  end

  // Fetch state registers. Reset drops any read in flight.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_epoch_q <= 1'b0;
      rd_addr_q  <= RESET_PC;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      rd_vld_q   <= rd_vld_d;
      rd_epoch_q <= rd_epoch_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RST_ADDR (RESET_PC),
    .CNT_W    (CNT_W)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_push  (live_rd),
    .i_data  (i_mem_data),
    .i_addr  (rd_addr_q),
    .i_pop   (pop),
    .i_flush (i_pc_load),
    .o_data  (o_opcode),
    .o_addr  (o_pc),
    .o_full  (buf_full),
    .o_empty (buf_empty),
    .o_count (occ)
  );

endmodule
